// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// WIDTH-cycle unsigned multiply (shift-add) and divide (restoring) sharing one accumulator.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLL  = 4'b1011;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   add_sum;
    logic [WIDTH-1:0]   sub_dif;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic               last_iter;

    // Handshake: an op is taken on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and out_valid is a one-cycle completion pulse.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign res         = res_q;
    assign res_hi      = res_hi_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

    assign add_sum = a + b;
    assign sub_dif = a - b;
    assign shamt   = a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
            OP_SLL:  alu_res = b << shamt;
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_SUB: begin
                alu_res = sub_dif;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_dif[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                alu_res = add_sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

    // Multiply: upper half accumulates, lower half holds the unconsumed multiplier bits.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, opb_q};
    assign div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        res_hi_d    = res_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MULU) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        opa_d   = a;
                        opb_d   = b;
                    end else if (op == OP_DIVU) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        opa_d   = a;
                        opb_d   = b;
                    end else begin
                        res_d       = alu_res;
                        res_hi_d    = '0;
                        zero_d      = (alu_res == '0);
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + SHW'(1);
                if (last_iter) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    res_d       = mul_next[WIDTH-1:0];
                    res_hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_next[WIDTH-1:0] == '0);
                    ovf_d       = |mul_next[2*WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + SHW'(1);
                if (last_iter) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    // Divide by zero still runs the full latency, then reports all-ones / dividend.
                    if (opb_q == '0) begin
                        res_d    = '1;
                        res_hi_d = opa_q;
                        zero_d   = 1'b0;
                        ovf_d    = 1'b1;
                    end else begin
                        res_d    = div_next[WIDTH-1:0];
                        res_hi_d = div_next[2*WIDTH-1:WIDTH];
                        zero_d   = (div_next[WIDTH-1:0] == '0);
                        ovf_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            res_hi_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            res_hi_q    <= res_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=32 and a WIDTH=8 instance, driven with directed and
// random ops, checked against an arithmetic reference model through a scoreboard.
module tb_alu_seq;

    typedef struct {
        int          inst;
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld [2];
    logic [3:0]  opv [2];
    logic [31:0] av  [2];
    logic [31:0] bv  [2];

    wire         rdy   [2];
    wire         ov    [2];
    wire         zr    [2];
    wire         of    [2];
    wire  [31:0] res_w [2];
    wire  [31:0] hi_w  [2];
    wire  [1:0]  st_w  [2];

    exp_t        exp_q[$];
    logic [65:0] last [2];
    int          busy_end [2];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .op(opv[0]),
        .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .res(res_w[0]), .res_hi(hi_w[0]),
        .zero(zr[0]), .overflow(of[0]), .dbg_state_o(st_w[0])
    );

    alu_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .op(opv[1]),
        .a(av[1][7:0]), .b(bv[1][7:0]), .out_valid(ov[1]), .res(res_w[1][7:0]),
        .res_hi(hi_w[1][7:0]), .zero(zr[1]), .overflow(of[1]), .dbg_state_o(st_w[1])
    );
    assign res_w[1][31:8] = '0;
    assign hi_w[1][31:8]  = '0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic msb(input longint unsigned v, input int w);
        return v[w-1];
    endfunction

    // Reference: plain arithmetic on masked 64-bit values.
    function automatic exp_t model(input int inst, input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned m, ua, ub, r, p, hi;
        int sh;
        m  = (64'd1 << w) - 64'd1;
        ua = a & m;
        ub = b & m;
        sh = int'(ua % longint'(w));
        r  = 0;
        hi = 0;
        e.ovf = 1'b0;
        case (op)
            4'd0: r = ua & ub;
            4'd1: r = ua | ub;
            4'd3: r = ua ^ ub;
            4'd4: r = ~(ua | ub) & m;
            4'd5: r = ub >> sh;
            4'd7: r = (ua < ub) ? 1 : 0;
            4'd6: begin
                r = (ua - ub) & m;
                e.ovf = (msb(ua, w) != msb(ub, w)) && (msb(r, w) != msb(ua, w));
            end
            4'd8: begin
                p  = ua * ub;
                r  = p & m;
                hi = (p >> w) & m;
                e.ovf = (hi != 0);
            end
            4'd9: begin
                if (ub == 0) begin
                    r = m;
                    hi = ua;
                    e.ovf = 1'b1;
                end else begin
                    r  = ua / ub;
                    hi = ua % ub;
                end
            end
            4'd10: r = msb(ub, w) ? (((ub | ~m) >> sh) & m) : (ub >> sh);
            4'd11: r = (ub << sh) & m;
            default: begin
                r = (ua + ub) & m;
                e.ovf = (msb(ua, w) == msb(ub, w)) && (msb(r, w) != msb(ua, w));
            end
        endcase
        e.inst = inst;
        e.res  = r[31:0];
        e.hi   = hi[31:0];
        e.zero = (r == 0);
        e.due  = 0;
        return e;
    endfunction

    task automatic mon(input int i);
        int   w;
        int   idx;
        exp_t e;
        w   = (i == 0) ? 32 : 8;
        idx = -1;
        check($sformatf("in_ready%0d", i), rdy[i], cyc >= busy_end[i]);
        if (ov[i]) begin
            foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == i) idx = j;
            if (idx < 0) begin
                check($sformatf("spurious_out_valid%0d", i), 1, 0);
            end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                check($sformatf("latency%0d", i), cyc, e.due);
                check($sformatf("res%0d", i), res_w[i], e.res);
                check($sformatf("res_hi%0d", i), hi_w[i], e.hi);
                check($sformatf("zero%0d", i), zr[i], e.zero);
                check($sformatf("overflow%0d", i), of[i], e.ovf);
                last[i] = {e.res, e.hi, e.zero, e.ovf};
            end
        end else begin
            check($sformatf("hold%0d", i), {res_w[i], hi_w[i], zr[i], of[i]}, last[i]);
        end
        if (vld[i] && rdy[i]) begin
            e = model(i, w, opv[i], av[i], bv[i]);
            e.due = cyc + 1 + ((opv[i] == 4'd8 || opv[i] == 4'd9) ? w : 0);
            if (opv[i] == 4'd8 || opv[i] == 4'd9) busy_end[i] = cyc + 1 + w;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        vld[i] = 1'b1;
        opv[i] = op;
        av[i]  = a;
        bv[i]  = b;
        forever begin
            @(negedge clk);
            if (rdy[i]) break;
            t++;
            if (t > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_in_ready"}, rdy[i], 1);
            check({tag, "_out_valid"}, ov[i], 0);
            check({tag, "_outputs"}, {res_w[i], hi_w[i], zr[i], of[i]}, 66'd0);
        end
    endtask

    task automatic rand_ops(input int i, input int n);
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < n; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
            issue(i, op, a, b);
            if ($urandom_range(0, 4) == 0) begin
                vld[i] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0;
            opv[i] = '0;
            av[i]  = '0;
            bv[i]  = '0;
            last[i] = '0;
            busy_end[i] = 0;
        end
        #3;
        check_reset_outputs("reset");
        check("reset_state0", st_w[0], 0);
        check("reset_state1", st_w[1], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Legacy ops, back-to-back on the 32-bit instance.
        issue(0, 4'd0, 32'hF0F0_00FF, 32'h0FF0_FF00);
        issue(0, 4'd1, 32'hF0F0_00FF, 32'h0FF0_FF00);
        issue(0, 4'd3, 32'hF0F0_00FF, 32'h0FF0_FF00);
        issue(0, 4'd4, 32'hF0F0_00FF, 32'h0FF0_FF00);
        issue(0, 4'd7, 32'h0000_0001, 32'hFFFF_FFFF);
        issue(0, 4'd5, 32'h0000_0001, 32'h8000_0000);
        issue(0, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(0, 4'd6, 32'h8000_0000, 32'h0000_0001);
        issue(0, 4'd6, 32'h0000_0005, 32'h0000_0005);
        issue(0, 4'd13, 32'h0000_0010, 32'h0000_0020);
        // Multiply then an op waiting on in_ready, accepted right after completion.
        issue(0, 4'd8, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(0, 4'd2, 32'h0000_0003, 32'h0000_0004);
        issue(0, 4'd9, 32'd100, 32'd7);
        issue(0, 4'd9, 32'd9, 32'd0);
        drain();

        // Reset in the middle of a divide discards it.
        issue(0, 4'd9, 32'd100, 32'd7);
        vld[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        busy_end[0] = 0;
        busy_end[1] = 0;
        last[0] = '0;
        last[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue(0, 4'd2, 32'd1, 32'd2);
        drain();

        rand_ops(0, 60);
        drain();

        // 8-bit instance.
        issue(1, 4'd8, 32'd15, 32'd17);
        issue(1, 4'd10, 32'd3, 32'h80);
        issue(1, 4'd11, 32'd7, 32'h01);
        issue(1, 4'd8, 32'hFF, 32'hFF);
        issue(1, 4'd9, 32'd200, 32'd13);
        issue(1, 4'd9, 32'd5, 32'd0);
        issue(1, 4'd2, 32'h7F, 32'h01);
        rand_ops(1, 80);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the multi-cycle datapath with a valid/ready handshake.
- Op codes 0000–0111 keep the existing 3-bit ALU encoding, generalised to WIDTH bits, and complete in one cycle.
- Op codes 1000–1011 add unsigned multiply, unsigned divide, arithmetic right shift and left shift.
- Multiply and divide are iterative and take WIDTH cycles.
- It sits in EX and stalls the pipeline through in_ready.
- Flags zero and overflow are fully defined and registered with the result.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH) (derived, not overridable), shift-amount width.

- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  op/a/b valid this cycle.
- in_ready  output  1  block can accept; high exactly when FSM is IDLE.
- op  input  4  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse, result registers updated.
- res  output  WIDTH  primary result.
- res_hi  output  WIDTH  product high half (mul) / remainder (div); 0 for other ops.
- zero  output  1  res == 0.
- overflow  output  1  op-specific, see Operation.

## Operation
- Accept on a rising edge where in_valid && in_ready; a, b, op are captured and in_valid is ignored when in_ready=0.
- Op set:
  - 0000 and: a&b.
  - 0001 or: a|b.
  - 0010 add: a+b.
  - 0110 sub: a-b.
  - 0100 nor: ~(a|b).
  - 0111 sltu: (a<b unsigned) ? 1 : 0.
  - 0011 xor: a^b.
  - 0101 srl: b >> a[SHW-1:0], logical.
  - 1000 mulu: {res_hi,res} = a*b unsigned.
  - 1001 divu: res = a/b, res_hi = a%b, unsigned.
  - 1010 sra: b >>> a[SHW-1:0].
  - 1011 sll: b << a[SHW-1:0].
  - 1100–1111: behave as add.
- overflow:
  - add: signed overflow, i.e. a,b same sign and res sign differs.
  - sub: a,b differ in sign and res sign differs from a.
  - mulu: res_hi != 0.
  - divu: b == 0.
  - Otherwise 0.
- Divide by zero: res = all ones, res_hi = a, overflow = 1, same latency as normal divide.
- FSM states:
  - IDLE: accepts any op.
    - Single-cycle op → compute, load output regs, stay IDLE.
    - mulu → MUL.
    - divu → DIV.
  - MUL: shift-add, one bit of b per cycle, 2*WIDTH-bit accumulator; iteration counter counts 0..WIDTH-1; after the last iteration load outputs, go IDLE.
  - DIV: restoring shift-subtract, one quotient bit per cycle, same counter; after the last iteration load outputs, go IDLE.
- res/res_hi/zero/overflow change only on the edge that raises out_valid; they hold until the next completion.

## Timing
- Reset (rst_n=0, any time, including mid MUL/DIV):
  - FSM IDLE, counter 0, accumulator cleared.
  - res=0, res_hi=0, zero=0, overflow=0, out_valid=0.
  - in_ready=1 as soon as rst_n is low; an in-flight op is discarded with no out_valid.
- Single-cycle ops:
  - Accepted at edge k → out_valid=1 in cycle k..k+1, i.e. latency 1.
  - Back-to-back issue every cycle is allowed; out_valid stays high continuously.
- mulu/divu:
  - Accepted at edge k → in_ready=0 from edge k to edge k+WIDTH.
  - out_valid pulses for one cycle after edge k+WIDTH, i.e. latency WIDTH.
  - in_ready=1 in that same cycle, so a new op may be accepted on edge k+WIDTH+1.
- Counter wrap: the counter reaching WIDTH-1 triggers completion and resets to 0; no extra idle cycle.
- out_valid is never high two cycles in a row for the same op; there is no output back-pressure.
- No combinational path from inputs to outputs other than in_ready from state.

## Test plan
- Reset mid-divide: WIDTH=32, issue divu a=100 b=7, assert rst_n=0 at cycle 10 → in_ready=1, res=0, no out_valid; after release, add a=1 b=2 → res=3 next cycle.
- Legacy ops at WIDTH=32, back-to-back, one per cycle:
  - and/or/xor/nor on 0xF0F0_00FF/0x0FF0_FF00 → correct words every cycle.
  - sltu 1 vs 0xFFFF_FFFF → 1.
  - srl b=0x8000_0000 a=1 → 0x4000_0000.
- Overflow flags:
  - add 0x7FFF_FFFF+1 → res 0x8000_0000, overflow=1.
  - sub 0x8000_0000-1 → overflow=1.
  - sub 5-5 → res 0, zero=1, overflow=0.
- mulu 0xFFFF_FFFF*2 → in_ready low 32 cycles; out_valid at latency 32, res=0xFFFF_FFFE, res_hi=1, overflow=1; op issued the same cycle as out_valid is accepted.
- divu 100/7 → res=14, res_hi=2, latency 32; divu 9/0 → res=0xFFFF_FFFF, res_hi=9, overflow=1.
- WIDTH=8: mulu 15*17 → res=0xFF, res_hi=0 at latency 8; sra 0x80 by 3 → 0xF0; sll 0x01 by 7 → 0x80.
